// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
//   Shared definitions for the control pipeline: default field widths,
//   forwarding select codes, the per-stage control bundle layouts and a
//   small helper that resolves forwarding priority.
//   No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

  localparam int ALUOP_W_DEF = 5;
  localparam int REG_W_DEF   = 5;

  // Operand source select driven to the EX-stage operand muxes
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // Control flags held in ID/EX (an all-zero bundle is a bubble)
  typedef struct packed {
    logic regw;
    logic memr;
    logic mem2r;
    logic memw;
    logic alusrc;
    logic branch;
  } ex_ctrl_t;

  // Control flags held in EX/MEM
  typedef struct packed {
    logic regw;
    logic memr;
    logic mem2r;
    logic memw;
  } mem_ctrl_t;

  // Control flags held in MEM/WB
  typedef struct packed {
    logic regw;
    logic mem2r;
  } wb_ctrl_t;

  // The younger result (EX/MEM) must win over the older one (MEM/WB)
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_EXMEM;
    if (wb_hit)  return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_stage
//   Generic pipeline register: async clear on reset, synchronous clear used
//   to inject a bubble, and a load enable. Clear has priority over enable.
//   Ports:
//     clk_i   rising-edge clock
//     rst_ni  async active-low reset (register -> 0)
//     en_i    load d_i on the next edge
//     clr_i   load all-zero on the next edge
//     d_i     next value
//     q_o     registered value
// ---------------------------------------------------------------------------
module ctrl_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i)     data_d = '0;
    else if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//   Carries decoder control ID->EX->MEM->WB, resolves the write register,
//   detects load-use hazards, squashes on taken branch / jump and drives the
//   EX forwarding selects.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     id_*_i                        decoder bundle + register indices in ID
//     ex_zero_i                     ALU zero flag of the instruction in EX
//     pc_we_o, ifid_we_o            front-end write enables (0 = hold)
//     flush_ifid_o                  clear IF/ID on the next edge
//     br_taken_o                    taken branch in EX (PC select)
//     ex_*_o, fwd_a_o, fwd_b_o      EX-stage controls and operand selects
//     mem_*_o, wb_*_o               MEM / WB controls and destination indices
// ---------------------------------------------------------------------------
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               id_valid_i,
  input  logic               id_regw_i,
  input  logic               id_regdst_i,
  input  logic               id_memr_i,
  input  logic               id_mem2r_i,
  input  logic               id_memw_i,
  input  logic               id_alusrc_i,
  input  logic               id_branch_i,
  input  logic               id_jump_i,
  input  logic [ALUOP_W-1:0] id_aluop_i,
  input  logic [REG_W-1:0]   id_rs_i,
  input  logic [REG_W-1:0]   id_rt_i,
  input  logic [REG_W-1:0]   id_rd_i,
  input  logic               ex_zero_i,
  output logic               pc_we_o,
  output logic               ifid_we_o,
  output logic               flush_ifid_o,
  output logic               br_taken_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_branch_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o,
  output logic               mem_memr_o,
  output logic               mem_memw_o,
  output logic               mem_mem2r_o,
  output logic               mem_regw_o,
  output logic [REG_W-1:0]   ex_wreg_o,
  output logic [REG_W-1:0]   mem_wreg_o,
  output logic [REG_W-1:0]   wb_wreg_o,
  output logic               wb_regw_o,
  output logic               wb_mem2r_o
);

  typedef struct packed {
    ex_ctrl_t           ctrl;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   wreg;
  } idex_t;

  typedef struct packed {
    mem_ctrl_t        ctrl;
    logic [REG_W-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t         ctrl;
    logic [REG_W-1:0] wreg;
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic uses_rt;
  logic hazard;
  logic br_taken;
  logic idex_bubble;

  // Stores read rt as data even though alusrc selects the immediate
  assign uses_rt = ~id_alusrc_i | id_memw_i;

  assign hazard = idex_q.ctrl.memr && (idex_q.wreg != '0) &&
                  ((idex_q.wreg == id_rs_i) || (uses_rt && (idex_q.wreg == id_rt_i)));

  assign br_taken = idex_q.ctrl.branch & ex_zero_i;

  // A taken branch flushes whatever is in ID, so it also cancels the stall
  assign pc_we_o      = ~hazard | br_taken;
  assign ifid_we_o    = ~hazard | br_taken;
  assign flush_ifid_o = br_taken | (id_jump_i & id_valid_i & ~hazard);
  assign br_taken_o   = br_taken;

  // A jump is resolved in ID and never needs to travel further down
  assign idex_bubble = br_taken | hazard | ~id_valid_i | id_jump_i;

  always_comb begin
    idex_d             = '0;
    idex_d.ctrl.regw   = id_regw_i;
    idex_d.ctrl.memr   = id_memr_i;
    idex_d.ctrl.mem2r  = id_mem2r_i;
    idex_d.ctrl.memw   = id_memw_i;
    idex_d.ctrl.alusrc = id_alusrc_i;
    idex_d.ctrl.branch = id_branch_i;
    idex_d.aluop       = id_aluop_i;
    idex_d.rs          = id_rs_i;
    idex_d.rt          = id_rt_i;
    idex_d.wreg        = id_regdst_i ? id_rd_i : id_rt_i;
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.ctrl.regw  = idex_q.ctrl.regw;
    exmem_d.ctrl.memr  = idex_q.ctrl.memr;
    exmem_d.ctrl.mem2r = idex_q.ctrl.mem2r;
    exmem_d.ctrl.memw  = idex_q.ctrl.memw;
    exmem_d.wreg       = idex_q.wreg;
  end

  always_comb begin
    memwb_d            = '0;
    memwb_d.ctrl.regw  = exmem_q.ctrl.regw;
    memwb_d.ctrl.mem2r = exmem_q.ctrl.mem2r;
    memwb_d.wreg       = exmem_q.wreg;
  end

  ctrl_pipe_stage #(.W($bits(idex_t))) u_idex (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .clr_i  (idex_bubble),
    .d_i    (idex_d),
    .q_o    (idex_q)
  );

  ctrl_pipe_stage #(.W($bits(exmem_t))) u_exmem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .d_i    (exmem_d),
    .q_o    (exmem_q)
  );

  ctrl_pipe_stage #(.W($bits(memwb_t))) u_memwb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .d_i    (memwb_d),
    .q_o    (memwb_q)
  );

  // Register 0 is hard-wired, so a write to it must never be forwarded
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  assign mem_hit_a = exmem_q.ctrl.regw && (exmem_q.wreg != '0) && (exmem_q.wreg == idex_q.rs);
  assign mem_hit_b = exmem_q.ctrl.regw && (exmem_q.wreg != '0) && (exmem_q.wreg == idex_q.rt);
  assign wb_hit_a  = memwb_q.ctrl.regw && (memwb_q.wreg != '0) && (memwb_q.wreg == idex_q.rs);
  assign wb_hit_b  = memwb_q.ctrl.regw && (memwb_q.wreg != '0) && (memwb_q.wreg == idex_q.rt);

  assign fwd_a_o = fwd_select(mem_hit_a, wb_hit_a);
  assign fwd_b_o = fwd_select(mem_hit_b, wb_hit_b);

  assign ex_aluop_o  = idex_q.aluop;
  assign ex_alusrc_o = idex_q.ctrl.alusrc;
  assign ex_branch_o = idex_q.ctrl.branch;
  assign ex_wreg_o   = idex_q.wreg;

  assign mem_memr_o  = exmem_q.ctrl.memr;
  assign mem_memw_o  = exmem_q.ctrl.memw;
  assign mem_mem2r_o = exmem_q.ctrl.mem2r;
  assign mem_regw_o  = exmem_q.ctrl.regw;
  assign mem_wreg_o  = exmem_q.wreg;

  assign wb_regw_o   = memwb_q.ctrl.regw;
  assign wb_mem2r_o  = memwb_q.ctrl.mem2r;
  assign wb_wreg_o   = memwb_q.wreg;

endmodule
